instr_encoder: RTL and testbench
================================

# instr_encoder

Streaming RV32I instruction encoder for load (I-type), store (S-type) and branch (B-type) instructions. Each transaction carries a format, register fields, funct3 and a full 32-bit immediate. The block range-checks the immediate, scatters it into the architectural bit positions and emits the 32-bit instruction word with a sequential word address. It sits in the test/program-load path: it produces the instruction memory image that the core's fetch and decode stages later consume.

## Interface
- DEPTH, 64: number of instruction words the block may emit before it reports full; must be at least 2.
- HALT_ON_ERR, 0: when 1, any rejected transaction stops acceptance until `restart`.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- restart  in  1  synchronous clear of the address counter, error state and output register.
- in_valid  in  1  a transaction is presented.
- in_ready  out  1  the block accepts the transaction this cycle.
- in_fmt  in  2  0=load I-type, 1=store S-type, 2=branch B-type, 3=illegal.
- in_funct3  in  3  copied to instr[14:12].
- in_rd  in  5  copied to instr[11:7]; used for I-type only.
- in_rs1  in  5  copied to instr[19:15].
- in_rs2  in  5  copied to instr[24:20]; used for S-type and B-type.
- in_imm  in  32  signed byte offset.
- out_valid  out  1  out_instr and out_addr hold a word.
- out_ready  in  1  the consumer takes the word.
- out_instr  out  32  encoded instruction.
- out_addr  out  $clog2(DEPTH)  word index of out_instr.
- count  out  $clog2(DEPTH)+1  number of words accepted for emission.
- full  out  1  count == DEPTH.
- err  out  1  sticky; set by any rejected transaction.
- err_code  out  2  last error: 0=none, 1=immediate out of range, 2=misaligned branch, 3=illegal format.
- err_cnt  out  8  count of rejected transactions; saturates at 255.

## Operation
- **Opcodes:** I-type 0000011, S-type 0100011, B-type 1100011, placed in instr[6:0].
- **I-type:** instr[31:20] = imm[11:0].
- **S-type:** instr[31:25] = imm[11:5]; instr[11:7] = imm[4:0].
- **B-type:** instr[31] = imm[12]; instr[30:25] = imm[10:5]; instr[11:8] = imm[4:1]; instr[7] = imm[11].
- **Unused fields:** fields a format does not use are driven to 0. Example: rs2 is 0 in an I-type word.
- **Range rules:** for I-type and S-type, imm[31:11] must be all equal, otherwise code 1. For B-type, imm[31:12] must be all equal, otherwise code 1. For B-type, imm[0] must be 0, otherwise code 2. in_fmt = 3 gives code 3.
- **Error priority:** code 3, then code 2, then code 1.
- **Rejected transaction:** it is consumed, since the handshake completes, but it is not emitted and count does not change. err is set, err_code is updated and err_cnt is incremented.
- **States:**
  - RUN: normal operation.
  - HALT: entered from RUN on a rejection when HALT_ON_ERR=1. in_ready = 0 in HALT.
  - HALT is left only by restart or reset, which both return the block to RUN.
- **in_ready:** in_ready = (state==RUN) && !full && !restart && (!out_valid || out_ready).
- **Accepted good transaction:** the output register loads out_instr and sets out_addr = count. count increments.
- **Full:** when count reaches DEPTH, full = 1 and in_ready = 0. There is no wrap-around; only restart or reset clears full.
- **restart:** clears count, out_valid, err, err_code and err_cnt, and sets state to RUN. restart has priority over a same-cycle handshake, which does not occur because in_ready = 0.
- **reset:** applies the same clearing as restart.

## Timing
- **Reset values:** in_ready=0 during the reset cycle, then 1; out_valid=0; out_instr=0; out_addr=0; count=0; full=0; err=0; err_code=0; err_cnt=0.
- **Latency:** 1 cycle. A handshake at edge N makes out_valid=1 after edge N.
- **Throughput:** one word per cycle while out_ready=1.
- **Backpressure:** while out_valid && !out_ready, out_instr and out_addr hold stable and in_ready=0.
- **Simultaneous events:** an output consumed and a new input accepted in the same cycle give a back-to-back update with no bubble.
- **Rejection:** out_valid falls after the edge if the previous word was consumed and nothing new was accepted. err, err_code and err_cnt update on the same edge as the rejecting handshake.
- **restart mid-stream:** a word pending on the output is discarded; out_valid=0 after the restart edge.

## Test plan
- lw x5,-4(x2): fmt=0, funct3=010, rd=5, rs1=2, imm=0xFFFFFFFC -> out_instr=0xFFC12283 and out_addr=0, one cycle later.
- sw x6,8(x1): fmt=1, funct3=010, rs1=1, rs2=6, imm=8 -> 0x0060A423, out_addr=1. Then beq x1,x2,-8: fmt=2, funct3=000, imm=0xFFFFFFF8 -> 0xFE208CE3, out_addr=2.
- Errors:
  - I-type imm=0x800 -> no output, err_code=1, err_cnt=1.
  - B-type imm=5 -> err_code=2, err_cnt=2.
  - fmt=3 -> err_code=3, err_cnt=3.
  - In all three cases count is unchanged.
- HALT_ON_ERR=1: after one rejection, in_ready stays 0 for 10 cycles with in_valid=1. After restart, in_ready=1 and err=0.
- Backpressure: hold out_ready=0 for 3 cycles -> out_instr stable and in_ready=0 for those 3 cycles. Then stream 4 words with out_ready=1 -> one word per cycle.
- DEPTH=4: offer 5 good transactions -> out_addr 0..3 emitted, full=1 and in_ready=0 after the 4th. Then restart -> count=0, full=0, and the next word has out_addr=0.

Source files
------------

// File: rtl/instr_encoder.sv
// Streaming RV32I load/store/branch encoder: range-checks the immediate, scatters it
// into the instruction word and emits it with a sequential word address.
module instr_encoder #(
  parameter int DEPTH       = 64,
  parameter bit HALT_ON_ERR = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       restart,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_fmt,
  input  logic [2:0]                 in_funct3,
  input  logic [4:0]                 in_rd,
  input  logic [4:0]                 in_rs1,
  input  logic [4:0]                 in_rs2,
  input  logic [31:0]                in_imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [$clog2(DEPTH)-1:0]   out_addr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       err,
  output logic [1:0]                 err_code,
  output logic [7:0]                 err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic {RUN, HALT} state_e;

  state_e         state_q;
  logic [CW-1:0]  count_q;
  logic           out_valid_q;
  logic [31:0]    out_instr_q;
  logic [AW-1:0]  out_addr_q;
  logic           err_q;
  logic [1:0]     err_code_q;
  logic [7:0]     err_cnt_q;

  logic           full_d;
  logic           fire_d;
  logic           imm_is_ok_d;
  logic           imm_b_ok_d;
  logic [1:0]     code_d;
  logic [31:0]    instr_d;

  assign full_d = (count_q == CW'(DEPTH));
  assign in_ready = (state_q == RUN) && !full_d && !restart && !reset &&
                    (!out_valid_q || out_ready);
  assign fire_d = in_valid && in_ready;

  // Immediate must be the sign extension of its encodable low bits.
  assign imm_is_ok_d = (&in_imm[31:11]) || !(|in_imm[31:11]);
  assign imm_b_ok_d  = (&in_imm[31:12]) || !(|in_imm[31:12]);

  always_comb begin
    code_d = 2'd0;
    if (in_fmt == 2'd3) begin
      code_d = 2'd3;
    end else if (in_fmt == 2'd2) begin
      if (in_imm[0])        code_d = 2'd2;
      else if (!imm_b_ok_d) code_d = 2'd1;
    end else if (!imm_is_ok_d) begin
      code_d = 2'd1;
    end
  end

  always_comb begin
    instr_d = '0;
    case (in_fmt)
      2'd0: instr_d = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
      2'd1: instr_d = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
      2'd2: instr_d = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                       in_imm[4:1], in_imm[11], OP_BRANCH};
      default: instr_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      state_q     <= RUN;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= '0;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
      err_cnt_q   <= 8'd0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      if (fire_d) begin
        if (code_d == 2'd0) begin
          out_valid_q <= 1'b1;
          out_instr_q <= instr_d;
          out_addr_q  <= count_q[AW-1:0];
          count_q     <= count_q + CW'(1);
        end else begin
          // Rejected word is consumed but never emitted.
          err_q      <= 1'b1;
          err_code_q <= code_d;
          if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
          if (HALT_ON_ERR) state_q <= HALT;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign count     = count_q;
  assign full      = full_d;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: default, halt-on-error and DEPTH=4 instances share stimulus.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset, restart, in_valid, out_ready;
  logic [1:0]  in_fmt;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;

  // Default instance (DEPTH=64, HALT_ON_ERR=0)
  logic        a_in_ready, a_out_valid, a_full, a_err;
  logic [31:0] a_out_instr;
  logic [5:0]  a_out_addr;
  logic [6:0]  a_count;
  logic [1:0]  a_err_code;
  logic [7:0]  a_err_cnt;

  // Halt-on-error instance
  logic        h_in_ready, h_out_valid, h_full, h_err;
  logic [31:0] h_out_instr;
  logic [5:0]  h_out_addr;
  logic [6:0]  h_count;
  logic [1:0]  h_err_code;
  logic [7:0]  h_err_cnt;

  // DEPTH=4 instance
  logic        s_in_ready, s_out_valid, s_full, s_err;
  logic [31:0] s_out_instr;
  logic [1:0]  s_out_addr;
  logic [2:0]  s_count;
  logic [1:0]  s_err_code;
  logic [7:0]  s_err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(64), .HALT_ON_ERR(1'b0)) u_dut (
    .clk(clk), .reset(reset), .restart(restart), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_fmt(in_fmt), .in_funct3(in_funct3), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .out_valid(a_out_valid), .out_ready(out_ready), .out_instr(a_out_instr),
    .out_addr(a_out_addr), .count(a_count), .full(a_full), .err(a_err),
    .err_code(a_err_code), .err_cnt(a_err_cnt));

  instr_encoder #(.DEPTH(64), .HALT_ON_ERR(1'b1)) u_halt (
    .clk(clk), .reset(reset), .restart(restart), .in_valid(in_valid), .in_ready(h_in_ready),
    .in_fmt(in_fmt), .in_funct3(in_funct3), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .out_valid(h_out_valid), .out_ready(out_ready), .out_instr(h_out_instr),
    .out_addr(h_out_addr), .count(h_count), .full(h_full), .err(h_err),
    .err_code(h_err_code), .err_cnt(h_err_cnt));

  instr_encoder #(.DEPTH(4), .HALT_ON_ERR(1'b0)) u_small (
    .clk(clk), .reset(reset), .restart(restart), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_fmt(in_fmt), .in_funct3(in_funct3), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .out_valid(s_out_valid), .out_ready(out_ready), .out_instr(s_out_instr),
    .out_addr(s_out_addr), .count(s_count), .full(s_full), .err(s_err),
    .err_code(s_err_code), .err_cnt(s_err_cnt));

  task automatic drive(input logic [1:0] fmt, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    in_valid  = 1'b1;
    in_fmt    = fmt;
    in_funct3 = f3;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
  endtask

  task automatic drive_lw();   drive(2'd0, 3'b010, 5'd5, 5'd2, 5'd0, 32'hFFFF_FFFC); endtask
  task automatic drive_sw();   drive(2'd1, 3'b010, 5'd0, 5'd1, 5'd6, 32'h0000_0008); endtask
  task automatic drive_beq();  drive(2'd2, 3'b000, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8); endtask

  task automatic pulse_reset();
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(2'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_during: got %b want 0", a_in_ready); end
    reset = 1'b0;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after: got %b want 1", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
    checks++; if (a_out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr: got %h want 0", a_out_instr); end
    checks++; if (a_out_addr !== 6'd0) begin errors++; $display("FAIL reset_out_addr: got %0d want 0", a_out_addr); end
    checks++; if (a_count !== 7'd0 || a_full !== 1'b0) begin errors++; $display("FAIL reset_count_full: got %0d/%b want 0/0", a_count, a_full); end
    checks++; if (a_err !== 1'b0 || a_err_code !== 2'd0 || a_err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err: got %b/%0d/%0d want 0/0/0", a_err, a_err_code, a_err_cnt); end
  endtask

  task automatic test_encode();
    @(negedge clk);
    out_ready = 1'b1;
    drive_lw();
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b1 || a_out_instr !== 32'hFFC12283 || a_out_addr !== 6'd0) begin errors++; $display("FAIL enc_lw: got v=%b %h @%0d want v=1 ffc12283 @0", a_out_valid, a_out_instr, a_out_addr); end
    drive_sw();
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b1 || a_out_instr !== 32'h0060A423 || a_out_addr !== 6'd1) begin errors++; $display("FAIL enc_sw: got v=%b %h @%0d want v=1 0060a423 @1", a_out_valid, a_out_instr, a_out_addr); end
    drive_beq();
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b1 || a_out_instr !== 32'hFE208CE3 || a_out_addr !== 6'd2) begin errors++; $display("FAIL enc_beq: got v=%b %h @%0d want v=1 fe208ce3 @2", a_out_valid, a_out_instr, a_out_addr); end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0 || a_count !== 7'd3) begin errors++; $display("FAIL enc_drain: got v=%b count=%0d want v=0 count=3", a_out_valid, a_count); end
  endtask

  task automatic test_errors();
    drive(2'd0, 3'b010, 5'd5, 5'd2, 5'd0, 32'h0000_0800);
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0 || a_err !== 1'b1 || a_err_code !== 2'd1 || a_err_cnt !== 8'd1 || a_count !== 7'd3) begin errors++; $display("FAIL err_range: got v=%b err=%b code=%0d cnt=%0d count=%0d want 0/1/1/1/3", a_out_valid, a_err, a_err_code, a_err_cnt, a_count); end
    drive(2'd2, 3'b000, 5'd0, 5'd1, 5'd2, 32'h0000_0005);
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0 || a_err_code !== 2'd2 || a_err_cnt !== 8'd2 || a_count !== 7'd3) begin errors++; $display("FAIL err_misalign: got v=%b code=%0d cnt=%0d count=%0d want 0/2/2/3", a_out_valid, a_err_code, a_err_cnt, a_count); end
    drive(2'd3, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0);
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0 || a_err_code !== 2'd3 || a_err_cnt !== 8'd3 || a_count !== 7'd3) begin errors++; $display("FAIL err_fmt: got v=%b code=%0d cnt=%0d count=%0d want 0/3/3/3", a_out_valid, a_err_code, a_err_cnt, a_count); end
    // Odd and out of range: misalignment outranks range
    drive(2'd2, 3'b000, 5'd0, 5'd1, 5'd2, 32'h0000_1001);
    @(negedge clk);
    checks++; if (a_err_code !== 2'd2 || a_err_cnt !== 8'd4) begin errors++; $display("FAIL err_priority: got code=%0d cnt=%0d want 2/4", a_err_code, a_err_cnt); end
    // Most negative legal I-type immediate is accepted; err stays sticky
    drive(2'd0, 3'b000, 5'd0, 5'd0, 5'd0, 32'hFFFF_F800);
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b1 || a_out_instr !== 32'h80000003 || a_out_addr !== 6'd3 || a_count !== 7'd4) begin errors++; $display("FAIL imm_min: got v=%b %h @%0d count=%0d want v=1 80000003 @3 count=4", a_out_valid, a_out_instr, a_out_addr, a_count); end
    checks++; if (a_err !== 1'b1 || a_err_code !== 2'd2) begin errors++; $display("FAIL err_sticky: got err=%b code=%0d want 1/2", a_err, a_err_code); end
    in_valid = 1'b0;
  endtask

  task automatic test_halt();
    pulse_reset();
    out_ready = 1'b1;
    drive(2'd3, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0);
    @(negedge clk);
    checks++; if (h_err !== 1'b1 || h_err_code !== 2'd3) begin errors++; $display("FAIL halt_err: got err=%b code=%0d want 1/3", h_err, h_err_code); end
    drive_lw();
    for (int i = 0; i < 10; i++) begin
      checks++; if (h_in_ready !== 1'b0 || h_out_valid !== 1'b0) begin errors++; $display("FAIL halt_hold[%0d]: got ready=%b v=%b want 0/0", i, h_in_ready, h_out_valid); end
      @(negedge clk);
    end
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    #1;
    checks++; if (h_in_ready !== 1'b1 || h_err !== 1'b0 || h_err_cnt !== 8'd0) begin errors++; $display("FAIL halt_restart: got ready=%b err=%b cnt=%0d want 1/0/0", h_in_ready, h_err, h_err_cnt); end
    @(negedge clk);
    checks++; if (h_out_valid !== 1'b1 || h_out_instr !== 32'hFFC12283 || h_out_addr !== 6'd0) begin errors++; $display("FAIL halt_resume: got v=%b %h @%0d want v=1 ffc12283 @0", h_out_valid, h_out_instr, h_out_addr); end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_instr [4];
    exp_instr[0] = 32'h0060A423;
    exp_instr[1] = 32'hFE208CE3;
    exp_instr[2] = 32'hFFC12283;
    exp_instr[3] = 32'h80000003;
    pulse_reset();
    out_ready = 1'b0;
    drive_lw();
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b1 || a_out_instr !== 32'hFFC12283) begin errors++; $display("FAIL bp_first: got v=%b %h want v=1 ffc12283", a_out_valid, a_out_instr); end
    drive_sw();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (a_out_instr !== 32'hFFC12283 || a_out_addr !== 6'd0 || a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d]: got %h @%0d ready=%b v=%b want ffc12283 @0 ready=0 v=1", i, a_out_instr, a_out_addr, a_in_ready, a_out_valid); end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive_sw();
        1: drive_beq();
        2: drive_lw();
        default: drive(2'd0, 3'b000, 5'd0, 5'd0, 5'd0, 32'hFFFF_F800);
      endcase
      @(negedge clk);
      checks++; if (a_out_valid !== 1'b1 || a_out_instr !== exp_instr[i] || a_out_addr !== 6'(i + 1)) begin errors++; $display("FAIL stream[%0d]: got v=%b %h @%0d want v=1 %h @%0d", i, a_out_valid, a_out_instr, a_out_addr, exp_instr[i], i + 1); end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_count !== 7'd5 || a_out_valid !== 1'b0) begin errors++; $display("FAIL stream_end: got count=%0d v=%b want 5/0", a_count, a_out_valid); end
  endtask

  task automatic test_full();
    pulse_reset();
    out_ready = 1'b1;
    drive_lw();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (s_out_valid !== 1'b1 || s_out_addr !== 2'(i)) begin errors++; $display("FAIL full_addr[%0d]: got v=%b @%0d want v=1 @%0d", i, s_out_valid, s_out_addr, i); end
    end
    checks++; if (s_full !== 1'b1 || s_in_ready !== 1'b0 || s_count !== 3'd4) begin errors++; $display("FAIL full_set: got full=%b ready=%b count=%0d want 1/0/4", s_full, s_in_ready, s_count); end
    @(negedge clk);
    checks++; if (s_out_valid !== 1'b0 || s_count !== 3'd4 || s_full !== 1'b1) begin errors++; $display("FAIL full_fifth: got v=%b count=%0d full=%b want 0/4/1", s_out_valid, s_count, s_full); end
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    #1;
    checks++; if (s_count !== 3'd0 || s_full !== 1'b0 || s_in_ready !== 1'b1) begin errors++; $display("FAIL full_restart: got count=%0d full=%b ready=%b want 0/0/1", s_count, s_full, s_in_ready); end
    @(negedge clk);
    checks++; if (s_out_valid !== 1'b1 || s_out_addr !== 2'd0 || s_count !== 3'd1) begin errors++; $display("FAIL full_rewrite: got v=%b @%0d count=%0d want 1/0/1", s_out_valid, s_out_addr, s_count); end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_encode();
    test_errors();
    test_halt();
    test_back_to_back();
    test_full();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
